// File: rtl/uart_pkg.sv
// Shared constants for the UART TX path: FSM encodings and frame geometry.
package uart_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DATA_BITS        = 8;
  localparam int BAUD_W           = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  // tick depends only on the register so the FSM can feed clr_i back without a loop
  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the FIFO read port one at a time and serialises them onto txd.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_pop_en,
  input  logic [7:0] fifo_do,
  input  logic       fifo_rdy,
  output logic       txd,
  output logic       busy,
  output logic       err_no_rdy
);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       err_q, err_d;
  logic       txd_q, txd_d;
  logic       busy_q, pop_q;
  logic       tick, baud_clr, serial;

  assign serial   = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign baud_clr = (state_d != state_q) || !serial;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty) state_d = S_POP;
      S_POP:   state_d = S_WAIT;
      S_WAIT: begin
        if (fifo_rdy) begin
          shift_d = fifo_do;
          par_d   = (^fifo_do) ^ ODD;
          state_d = S_START;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_DATA) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == LAST_STOP) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // bit counter is reused for data and stop bits, so restart it per state
    if (state_d != state_q) bit_d = '0;
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      // txd trails the state by one clock; hold busy until the last stop bit has left the pin
      busy_q  <= (state_d != S_IDLE) || (state_q != S_IDLE);
      pop_q   <= (state_d == S_POP);
    end
  end

  assign fifo_pop_en = pop_q;
  assign txd         = txd_q;
  assign busy        = busy_q;
  assign err_no_rdy  = err_q;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: three DUT configurations fed by a 1-clk pop->rdy FIFO model.
module tb_uart_tx_fifo_drain;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [2:0] tx_en, pop, rdy, txd, busy, err;
  wire  [2:0] fifo_empty;
  logic [7:0] fdo [3];

  int n_tests = 0, n_fail = 0, cyc = 0;

  logic [7:0]  fmem [3][32];
  logic [11:0] efr  [3][32];
  int          elen [3][32];
  int wp[3]       = '{default: 0};
  int rp[3]       = '{default: 0};
  int erp[3]      = '{default: 0};
  int pop_cnt[3]  = '{default: 0};
  int last_pop[3] = '{default: 0};
  int fstart[3], flen[3], bcnt[3], bexp[3];
  logic [11:0] ffr[3], cap[3];
  logic pend[3], inframe[3], ferr[3], pbusy[3], skip[3];
  logic withhold[3];
  logic wused[3] = '{default: 1'b0};

  for (genvar g = 0; g < 3; g++) begin : g_empty
    assign fifo_empty[g] = (wp[g] == rp[g]);
  end

  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_pop_en(pop[0]), .fifo_do(fdo[0]), .fifo_rdy(rdy[0]), .txd(txd[0]),
    .busy(busy[0]), .err_no_rdy(err[0]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_pop_en(pop[1]), .fifo_do(fdo[1]), .fifo_rdy(rdy[1]), .txd(txd[1]),
    .busy(busy[1]), .err_no_rdy(err[1]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
    .fifo_pop_en(pop[2]), .fifo_do(fdo[2]), .fifo_rdy(rdy[2]), .txd(txd[2]),
    .busy(busy[2]), .err_no_rdy(err[2]));

  task automatic chk(input string nm, input int ch, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0d expected %0d", nm, ch, act, exp);
    end
  endtask

  // FIFO model and output monitor, sampled on the falling edge
  initial begin
    int k;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (!reset_n) begin
          pend[c] = 1'b0; rdy[c] = 1'b0; inframe[c] = 1'b0; pbusy[c] = 1'b0;
          bcnt[c] = 0; bexp[c] = 0; skip[c] = 1'b0;
        end else begin
          rdy[c] = 1'b0;
          if (pend[c]) begin
            if (withhold[c] && !wused[c]) begin
              wused[c] = 1'b1; skip[c] = 1'b1;
            end else if (rp[c] != wp[c]) begin
              rdy[c] = 1'b1; fdo[c] = fmem[c][rp[c]]; rp[c]++;
            end
          end
          pend[c] = pop[c];
          if (pop[c]) begin
            pop_cnt[c]++;
            last_pop[c] = cyc;
            chk("pop_nonempty", c, int'(wp[c] != rp[c]), 1);
          end
          if (!inframe[c] && txd[c] == 1'b0) begin
            chk("start_latency", c, cyc - last_pop[c], 3);
            if (erp[c] < rp[c]) begin
              ffr[c] = efr[c][erp[c]]; flen[c] = elen[c][erp[c]]; erp[c]++;
            end else begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_start ch%0d: got start bit with %0d frames pending, expected none", c, rp[c] - erp[c]);
              ffr[c] = '1; flen[c] = 10;
            end
            inframe[c] = 1'b1; fstart[c] = cyc; ferr[c] = 1'b0; cap[c] = '0;
            bexp[c] += 3 + 4 * flen[c];
          end
          if (inframe[c]) begin
            k = (cyc - fstart[c]) / 4;
            if (txd[c] != ffr[c][k]) ferr[c] = 1'b1;
            if ((cyc - fstart[c]) % 4 == 2) cap[c][k] = txd[c];
            if (cyc - fstart[c] == 4 * flen[c] - 1) begin
              inframe[c] = 1'b0;
              n_tests++;
              if (ferr[c]) begin
                n_fail++;
                $display("FAIL frame ch%0d: got bits 0x%03h expected 0x%03h (len %0d)", c, cap[c], ffr[c], flen[c]);
              end
            end
          end
          if (busy[c]) bcnt[c]++;
          if (pbusy[c] && !busy[c]) begin
            if (!skip[c]) chk("busy_len", c, bcnt[c], bexp[c]);
            bcnt[c] = 0; bexp[c] = 0; skip[c] = 1'b0;
          end
          pbusy[c] = busy[c];
        end
      end
      cyc++;
    end
  end

  task automatic push(input int c, input logic [7:0] b, input logic [11:0] fr, input int len);
    fmem[c][wp[c]] = b;
    efr[c][wp[c]]  = fr;
    elen[c][wp[c]] = len;
    wp[c]++;
  endtask

  task automatic wait_done(input int c, input int budget);
    int n = 0;
    while (!(erp[c] == wp[c] && !inframe[c] && !busy[c]) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout_done ch%0d: got %0d frames outstanding expected 0", c, wp[c] - erp[c]);
    end
  endtask

  task automatic wait_pops(input int c, input int target, input int budget);
    int n = 0;
    while (pop_cnt[c] < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_pops", c, pop_cnt[c], target);
  endtask

  initial begin
    reset_n = 1'b0;
    tx_en = 3'b000;
    withhold = '{default: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_txd", c, txd[c], 1);
      chk("rst_busy", c, busy[c], 0);
      chk("rst_pop", c, pop[c], 0);
      chk("rst_err", c, err[c], 0);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single 0xA5 frame
    tx_en = 3'b111;
    push(0, 8'hA5, 12'h34A, 10);
    wait_done(0, 200);
    chk("t1_pops", 0, pop_cnt[0], 1);

    // three back-to-back frames
    push(0, 8'h01, 12'h202, 10);
    push(0, 8'h02, 12'h204, 10);
    push(0, 8'h03, 12'h206, 10);
    wait_done(0, 400);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_pops", 0, pop_cnt[0], 4);
    chk("t2_err", 0, err[0], 0);

    // even parity + 2 stop, odd parity + 1 stop
    push(1, 8'h07, 12'hE0E, 12);
    push(2, 8'h07, 12'h40E, 11);
    wait_done(1, 200);
    wait_done(2, 200);
    chk("t3_pops", 1, pop_cnt[1], 1);
    chk("t3_pops", 2, pop_cnt[2], 1);

    // tx_en dropped mid-frame
    push(0, 8'h3C, 12'h278, 10);
    push(0, 8'hC3, 12'h386, 10);
    wait_pops(0, 5, 50);
    repeat (12) @(posedge clk);
    #1;
    tx_en[0] = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("t4_pops_held", 0, pop_cnt[0], 5);
    chk("t4_busy", 0, busy[0], 0);
    chk("t4_fifo_left", 0, wp[0] - rp[0], 1);
    tx_en[0] = 1'b1;
    wait_done(0, 300);
    chk("t4_pops", 0, pop_cnt[0], 6);

    // reset mid-DATA
    push(0, 8'h55, 12'h2AA, 10);
    wait_pops(0, 7, 50);
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_txd", 0, txd[0], 1);
    chk("t5_rst_busy", 0, busy[0], 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_idle_pops", 0, pop_cnt[0], 7);
    chk("t5_idle_txd", 0, txd[0], 1);
    chk("t5_idle_busy", 0, busy[0], 0);
    push(0, 8'h81, 12'h302, 10);
    wait_done(0, 200);
    chk("t5_pops", 0, pop_cnt[0], 8);
    chk("t5_err", 0, err[0], 0);

    // fifo_rdy withheld once
    withhold[0] = 1'b1;
    push(0, 8'h5A, 12'h2B4, 10);
    wait_done(0, 300);
    chk("t6_err", 0, err[0], 1);
    chk("t6_pops", 0, pop_cnt[0], 10);
    chk("t6_txd", 0, txd[0], 1);
    chk("t6_err_other", 1, err[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
